// File: rtl/debounce_pkg.sv
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared defaults and a counter-width helper for the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam int DB_TICKS_DEF   = 8;
    localparam int HOLD_TICKS_DEF = 1000;
    localparam int N_CH_MAX       = 32;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/db_channel.sv
// ============================================================================
// Module   : db_channel
// Purpose  : One button channel: synchronizer, debounce, edge and hold pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module db_channel
    import debounce_pkg::*;
#(
    parameter int DB_TICKS   = DB_TICKS_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int c_DB_W   = cnt_width(DB_TICKS);
    localparam int c_HOLD_W = cnt_width(HOLD_TICKS + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DB_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(HOLD_TICKS - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_clean;
    logic                r_rise;
    logic                r_fall;
    logic                r_hold;

    logic w_mismatch;
    logic w_db_done;
    logic w_hold_hit;

    assign w_mismatch = (r_sync2 != r_clean);
    assign w_db_done  = i_tick && w_mismatch && (r_db_cnt == c_DB_LAST);
    // Hold counter saturates, so the pulse fires only on the single reaching tick.
    assign w_hold_hit = i_tick && r_clean && (r_hold_cnt == c_HOLD_PRE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_clean    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;

            if (i_tick) begin
                if (!w_mismatch || w_db_done) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end

            if (w_db_done) begin
                r_clean <= r_sync2;
            end
            r_rise <= w_db_done && r_sync2;
            r_fall <= w_db_done && !r_sync2;

            if (!r_clean) begin
                r_hold_cnt <= '0;
            end else if (i_tick && (r_hold_cnt != c_HOLD_MAX)) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end
            r_hold <= w_hold_hit;
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_hold  = r_hold;

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module   : multi_debouncer
// Purpose  : N_CH independent debounced button channels with edge/hold pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DB_TICKS   = DB_TICKS_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            db_channel #(
                .DB_TICKS   (DB_TICKS),
                .HOLD_TICKS (HOLD_TICKS)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_tick  (tick),
                .i_btn   (btn_in[g]),
                .o_clean (clean[g]),
                .o_rise  (rise[g]),
                .o_fall  (fall[g]),
                .o_hold  (hold[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, 4, number of independent button channels (1..32).
REQ-002 Parameter DB_TICKS, 8, consecutive mismatching ticks required before a clean output changes (>=1).
REQ-003 Parameter HOLD_TICKS, 1000, ticks a clean level must stay high before a hold pulse (>=1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset: synchronous, active-low.
REQ-006 tick  input  1  sample enable (prescaler strobe); tie high for per-clock counting.
REQ-007 btn_in  input  N_CH  raw asynchronous button levels, one bit per channel.
REQ-008 clean  output  N_CH  debounced level per channel.
REQ-009 rise  output  N_CH  one-clock pulse when clean goes 0->1.
REQ-010 fall  output  N_CH  one-clock pulse when clean goes 1->0.
REQ-011 hold  output  N_CH  one-clock pulse when clean has been 1 for HOLD_TICKS ticks.

Function
REQ-012 Each btn_in bit SHALL pass through a 2-flop synchronizer clocked every cycle, independent of tick; sync output = s.
REQ-013 On a tick cycle with s == clean, the channel debounce counter SHALL clear to 0.
REQ-014 On a tick cycle with s != clean and counter < DB_TICKS-1, the counter SHALL increment by 1.
REQ-015 On a tick cycle with s != clean and counter == DB_TICKS-1, clean SHALL take s and the counter SHALL clear; no wrap or overflow is possible.
REQ-016 On non-tick cycles, the debounce and hold counters and clean SHALL hold their values.
REQ-017 With tick=1, a stable btn_in edge SHALL reach clean after exactly 2+DB_TICKS clock edges.
REQ-018 Counter width SHALL be $clog2(DB_TICKS) bits, minimum 1. With DB_TICKS=1, clean SHALL update on the first mismatching tick.
REQ-019 rise and fall SHALL be registered and asserted on the same edge that updates clean. They SHALL be high for exactly one clock and low otherwise.
REQ-020 The hold counter SHALL clear while clean=0. While clean=1, it SHALL increment on each tick and saturate at HOLD_TICKS.
REQ-021 hold SHALL pulse for one clock on the edge where the hold counter reaches HOLD_TICKS. It SHALL pulse once per press, never repeat, and never wrap.
REQ-022 A release before HOLD_TICKS SHALL produce no hold pulse.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 A mismatch shorter than DB_TICKS consecutive ticks (glitch) SHALL leave clean, rise and fall unchanged.

Reset
REQ-025 While rst_n=0 at a clk edge, the following SHALL be 0 on that edge: synchronizer flops, debounce counters, hold counters, clean, rise, fall and hold.
REQ-026 Reset asserted mid-count or mid-press SHALL abandon all progress with no pulse emitted. After release, a held button SHALL be re-detected via the full 2+DB_TICKS latency and SHALL produce a rise pulse.
REQ-027 Reset SHALL dominate tick and btn_in.

Structure
REQ-028 Package debounce_pkg SHALL hold the default constants DB_TICKS_DEF=8, HOLD_TICKS_DEF=1000 and N_CH_MAX=32.
REQ-029 A sub-module db_channel SHALL contain the per-channel logic: synchronizer, debounce counter, clean, rise, fall and hold logic.
REQ-030 multi_debouncer SHALL instantiate db_channel N_CH times with a generate loop, and SHALL contain no other logic.

Verification (N_CH=4, DB_TICKS=8, HOLD_TICKS=20, tick=1 unless stated)
REQ-031 Scenario 1: btn_in[0] 0->1 stable -> clean[0]=1 and rise[0]=1 exactly 10 edges later, rise for one clock; other channels stay 0.
REQ-032 Scenario 2: btn_in[1] high-pulse of 7 clocks -> clean, rise and fall on channel 1 never assert. A pulse of 9 clocks -> rise 10 edges after the pulse start, fall 10 edges after its end.
REQ-033 Scenario 3: btn_in[2] held high 40 clocks -> exactly one hold[2] pulse, 20 edges after the rise edge, and no second pulse. Held 25 clocks after rise then released -> one hold, one fall.
REQ-034 Scenario 4: tick high one cycle in four, btn_in[3] stable high -> clean[3] rises 8 ticks after sync, i.e. about 32 clocks, not 10.
REQ-035 Scenario 5: btn_in=4'b1111 simultaneously -> all four rise bits pulse on the same edge.
REQ-036 Scenario 6: rst_n low for one edge at count 5 of a press -> all outputs 0 on that edge. With the button still high, rise follows 10 edges after reset release.
